// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Write-side refill engine for the icache. On a fetch miss it requests every
// word of the missing block from remote memory, collects the responses (which
// may come back in any order) into a small block buffer, and streams them into
// the icache write port strictly in ascending word-offset order. When the last
// word has been consumed it pulses refill_done_o so the core can replay the
// fetch. A flush during the refill suppresses that pulse but still lets the
// block finish, so the icache's own write counter stays block-aligned.
//
// Optional feature (macro ICACHE_REFILL_CRITICAL_WORD_FIRST_EN):
//   requests start at the missed word offset and wrap around the block;
//   writes are still issued in order 0..N-1.
//
// Ports
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   miss_v_i, miss_pc_i         miss strobe and missing word PC (IDLE only)
//   flush_i                     cancel replay of the current refill
//   req_v_o, req_pc_o,
//   req_ready_i                 remote load request handshake
//   resp_v_i, resp_offset_i,
//   resp_data_i                 load response (always accepted)
//   w_v_o, w_pc_o, w_instr_o,
//   w_yumi_i                    icache write port (valid/yumi)
//   busy_o                      refill in progress
//   refill_done_o               one-cycle pulse: block written, replay allowed
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int icache_tag_width_p           = 12,
    parameter int icache_entries_p             = 1024,
    parameter int icache_block_size_in_words_p = 4,
    localparam int pc_width_lp = icache_tag_width_p + $clog2(icache_entries_p),
    localparam int off_w_lp    = $clog2(icache_block_size_in_words_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   miss_v_i,
    input  logic [pc_width_lp-1:0] miss_pc_i,
    input  logic                   flush_i,
    output logic                   req_v_o,
    output logic [pc_width_lp-1:0] req_pc_o,
    input  logic                   req_ready_i,
    input  logic                   resp_v_i,
    input  logic [off_w_lp-1:0]    resp_offset_i,
    input  logic [31:0]            resp_data_i,
    output logic                   w_v_o,
    output logic [pc_width_lp-1:0] w_pc_o,
    output logic [31:0]            w_instr_o,
    input  logic                   w_yumi_i,
    output logic                   busy_o,
    output logic                   refill_done_o
);

    localparam int N_LP = icache_block_size_in_words_p;
    // Counters carry one extra bit so that reaching N is distinguishable from 0.
    localparam logic [off_w_lp:0]   LP_N    = N_LP[off_w_lp:0];
    localparam logic [off_w_lp-1:0] LP_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                             r_state, w_state_n;
    logic [pc_width_lp-off_w_lp-1:0]    r_base_hi;
    logic [off_w_lp:0]                  r_req_cnt;
    logic [off_w_lp:0]                  r_wr_cnt;
    logic [N_LP-1:0]                    r_valid;
    logic [N_LP-1:0][31:0]              r_buf;
    logic                               r_cancel;

    logic [off_w_lp-1:0]                w_req_off;
    logic [off_w_lp-1:0]                w_wr_off;
    logic                               w_req_fire;
    logic                               w_wr_fire;
    logic                               w_fill;

`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
    logic [off_w_lp-1:0]                r_crit_off;
    // Natural truncation of the sum gives the modulo-N wrap.
    assign w_req_off = r_crit_off + r_req_cnt[off_w_lp-1:0];
`else
    logic                               w_unused_miss_off;
    assign w_req_off         = r_req_cnt[off_w_lp-1:0];
    assign w_unused_miss_off = ^miss_pc_i[off_w_lp-1:0];
`endif

    assign w_fill     = (r_state == S_FILL);
    assign w_wr_off   = r_wr_cnt[off_w_lp-1:0];

    assign req_v_o    = w_fill && (r_req_cnt < LP_N);
    assign req_pc_o   = {r_base_hi, w_req_off};
    assign w_req_fire = req_v_o && req_ready_i;

    // Valid bits are registered, so a response to the slot being waited on
    // is presented one cycle after it lands rather than combinationally.
    assign w_v_o      = w_fill && !r_wr_cnt[off_w_lp] && r_valid[w_wr_off];
    assign w_pc_o     = {r_base_hi, w_wr_off};
    assign w_instr_o  = r_buf[w_wr_off];
    assign w_wr_fire  = w_v_o && w_yumi_i;

    assign busy_o        = (r_state != S_IDLE);
    assign refill_done_o = (r_state == S_DONE) && !r_cancel;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= S_IDLE;
        else            r_state <= w_state_n;
    end

    // Next-state logic
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (miss_v_i) w_state_n = S_FILL;
            S_FILL:  if (w_wr_fire && (w_wr_off == LP_LAST)) w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Datapath: block base, counters, response buffer, cancel flag
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_base_hi  <= '0;
            r_req_cnt  <= '0;
            r_wr_cnt   <= '0;
            r_valid    <= '0;
            r_buf      <= '0;
            r_cancel   <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
            r_crit_off <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (miss_v_i) begin
                        r_base_hi  <= miss_pc_i[pc_width_lp-1:off_w_lp];
                        r_req_cnt  <= '0;
                        r_wr_cnt   <= '0;
                        r_valid    <= '0;
                        r_cancel   <= 1'b0;
`ifdef ICACHE_REFILL_CRITICAL_WORD_FIRST_EN
                        r_crit_off <= miss_pc_i[off_w_lp-1:0];
`endif
                    end
                end
                S_FILL: begin
                    if (w_req_fire) r_req_cnt <= r_req_cnt + 1'b1;
                    if (w_wr_fire)  r_wr_cnt  <= r_wr_cnt + 1'b1;
                    if (resp_v_i) begin
                        r_buf[resp_offset_i]   <= resp_data_i;
                        r_valid[resp_offset_i] <= 1'b1;
                    end
                    // Replay is cancelled, but the block still completes.
                    if (flush_i) r_cancel <= 1'b1;
                end
                S_DONE:  r_cancel <= 1'b0;
                default: ;
            endcase
        end
    end

    // A second response for a slot already filled is a protocol error.
    a_no_dup_resp: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (w_fill && resp_v_i) |-> !r_valid[resp_offset_i]);

endmodule
